// File: rtl/ahb_pkg.sv
// Shared AHB types for the decode/mux interconnect: transfer types, response
// encodings and the default-peripheral state encoding.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } trans_t;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_OK   = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_t;

endpackage

// File: rtl/ahb_default_prph.sv
// Built-in default peripheral: answers unmapped or security-violating transfers
// with a two-cycle ERROR and keeps a saturating count of those ERRORs.
module ahb_default_prph
  import ahb_pkg::*;
#(
  parameter int ErrCntWidth = 16
) (
  input  logic                   clk,
  input  logic                   nReset,
  input  logic                   capture,
  input  logic                   errReq,
  output logic                   ready,
  output logic                   resp,
  output logic [ErrCntWidth-1:0] errCnt,
  output logic [1:0]             state
);

  ds_state_t state_q, state_d;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= DS_OK;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b1;
    resp    = RESP_OKAY;
    case (state_q)
      DS_ERR1: begin
        ready   = 1'b0;
        resp    = RESP_ERROR;
        state_d = DS_ERR2;
      end
      DS_ERR2: begin
        resp = RESP_ERROR;
      end
      DS_OK:   ;
      default: state_d = DS_OK;
    endcase
    // A capture edge always decides the next data phase, including ERR2 -> ERR1.
    if (capture) begin
      state_d = errReq ? DS_ERR1 : DS_OK;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      errCnt <= '0;
    end else if (capture && errReq && (errCnt != '1)) begin
      errCnt <= errCnt + 1'b1;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/ahb_decode_mux.sv
// Single-controller AHB decoder and response mux: one-hot address-phase select,
// registered data-phase select, and a default peripheral for misses.
module ahb_decode_mux
  import ahb_pkg::*;
#(
  parameter int                 DataWidth   = 32,
  parameter int                 AddrWidth   = 32,
  parameter int                 PrphNum     = 4,
  parameter int                 SelBits     = 4,
  parameter logic [PrphNum-1:0] SecureOnly  = '0,
  parameter int                 ErrCntWidth = 16
) (
  input  logic                           clk,
  input  logic                           nReset,
  input  logic [AddrWidth-1:0]           addr,
  input  logic [1:0]                     trans,
  input  logic                           nonSec,
  output logic [PrphNum-1:0]             sel,
  input  logic [PrphNum*DataWidth-1:0]   prphRData,
  input  logic [PrphNum-1:0]             prphReady,
  input  logic [PrphNum-1:0]             prphResp,
  output logic [DataWidth-1:0]           rData,
  output logic                           ready,
  output logic                           resp,
  output logic [ErrCntWidth-1:0]         errCnt,
  output logic [1:0]                     dsState
);

  // Handshake: ready high at a rising clk edge completes the current data phase
  // and captures the address phase on addr/trans/nonSec in the same edge.

  logic [SelBits-1:0] idx;
  logic [PrphNum-1:0] sel_c;
  logic               hit;
  logic [PrphNum:0]   dsel;
  logic               def_ready;
  logic               def_resp;
  logic               unused_ok;

  assign idx = addr[AddrWidth-1 -: SelBits];

  always_comb begin
    sel_c = '0;
    for (int i = 0; i < PrphNum; i++) begin
      if ((idx == SelBits'(i)) && !(nonSec && SecureOnly[i])) begin
        sel_c[i] = 1'b1;
      end
    end
  end

  assign hit = |sel_c;
  assign sel = sel_c;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      dsel <= {1'b1, {PrphNum{1'b0}}};
    end else if (ready) begin
      dsel <= {~hit, sel_c};
    end
  end

  ahb_default_prph #(
    .ErrCntWidth(ErrCntWidth)
  ) u_default (
    .clk     (clk),
    .nReset  (nReset),
    .capture (ready),
    .errReq  (~hit & trans[1]),
    .ready   (def_ready),
    .resp    (def_resp),
    .errCnt  (errCnt),
    .state   (dsState)
  );

  always_comb begin
    rData = '0;
    ready = def_ready;
    resp  = def_resp;
    for (int i = 0; i < PrphNum; i++) begin
      if (dsel[i]) begin
        rData = prphRData[i*DataWidth +: DataWidth];
        ready = prphReady[i];
        resp  = prphResp[i];
      end
    end
  end

  assign unused_ok = &{1'b0, addr[AddrWidth-SelBits-1:0], trans[0]};

endmodule

// File: tb/tb_ahb_decode_mux.sv
// Bench for ahb_decode_mux: decode vector table, data-phase scoreboard, and
// hand-written wait-state, error, security, reset and saturation sequences.
module tb_ahb_decode_mux;
  import ahb_pkg::*;

  localparam logic [3:0] SEC   = 4'b0001;
  localparam logic [3:0] PRESP = 4'b1000;

  logic         clk = 1'b0;
  logic         nReset;
  logic [31:0]  addr;
  logic [1:0]   trans;
  logic         nonSec;
  logic [3:0]   sel;
  logic [127:0] prphRData;
  logic [3:0]   prphReady;
  logic [3:0]   prphResp;
  logic [31:0]  rData;
  logic         ready;
  logic         resp;
  logic [1:0]   errCnt;
  logic [1:0]   dsState;

  int checks   = 0;
  int failures = 0;

  logic [32:0] exp_q[$];
  logic        dp_active;

  logic [3:0]  s_sel;
  logic        s_ready;
  logic        s_resp;
  logic [31:0] s_rdata;
  logic [1:0]  s_err;
  logic [1:0]  s_st;

  typedef struct {
    logic [31:0] a;
    logic [1:0]  t;
    logic        ns;
    logic [3:0]  s;
  } vec_t;
  vec_t vt[9];

  ahb_decode_mux #(
    .DataWidth(32), .AddrWidth(32), .PrphNum(4), .SelBits(4),
    .SecureOnly(SEC), .ErrCntWidth(2)
  ) dut (
    .clk(clk), .nReset(nReset), .addr(addr), .trans(trans), .nonSec(nonSec),
    .sel(sel), .prphRData(prphRData), .prphReady(prphReady), .prphResp(prphResp),
    .rData(rData), .ready(ready), .resp(resp), .errCnt(errCnt), .dsState(dsState)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [32:0] model(input logic [31:0] a, input logic ns);
    int idx;
    idx = int'(a[31:28]);
    if (idx < 4 && !(ns && SEC[idx])) return {PRESP[idx], 32'hCAFE_0000 | 32'(idx)};
    return {1'b1, 32'h0};
  endfunction

  // One bus cycle: drive, sample at negedge, score completed data phase, track capture.
  task automatic cycle(input logic [31:0] a, input logic [1:0] t, input logic ns, input logic rdy);
    logic [32:0] e;
    addr = a; trans = t; nonSec = ns; prphReady = {4{rdy}};
    @(negedge clk);
    s_sel = sel; s_ready = ready; s_resp = resp; s_rdata = rData; s_err = errCnt; s_st = dsState;
    if (dp_active && ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("sb_rdata", rData, e[31:0]);
        chk("sb_resp", {31'd0, resp}, {31'd0, e[32]});
      end
      dp_active = 1'b0;
    end
    if (ready) begin
      dp_active = t[1];
      if (t[1]) exp_q.push_back(model(a, ns));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nReset = 1'b0;
    trans = IDLE;
    prphReady = 4'hF;
    exp_q.delete();
    dp_active = 1'b0;
    @(negedge clk);
    nReset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp_cnt [4];
    exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3;

    vt[0] = '{32'h2000_0010, NONSEQ, 1'b0, 4'b0100};
    vt[1] = '{32'h0000_0004, SEQ,    1'b0, 4'b0001};
    vt[2] = '{32'h0000_0004, SEQ,    1'b1, 4'b0000};
    vt[3] = '{32'h1000_0000, NONSEQ, 1'b1, 4'b0010};
    vt[4] = '{32'h3FFF_FFFC, NONSEQ, 1'b1, 4'b1000};
    vt[5] = '{32'h5000_0000, NONSEQ, 1'b0, 4'b0000};
    vt[6] = '{32'hF000_0000, IDLE,   1'b0, 4'b0000};
    vt[7] = '{32'h2000_0000, IDLE,   1'b1, 4'b0100};
    vt[8] = '{32'h4000_0000, NONSEQ, 1'b0, 4'b0000};

    for (int i = 0; i < 4; i++) prphRData[i*32 +: 32] = 32'hCAFE_0000 | 32'(i);
    prphResp  = PRESP;
    prphReady = 4'hF;
    addr = 32'h0; trans = IDLE; nonSec = 1'b0;
    dp_active = 1'b0;

    // Power-on reset state
    nReset = 1'b0;
    #3;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_resp", {31'd0, resp}, 32'd0);
    chk("rst_rdata", rData, 32'd0);
    chk("rst_errcnt", {30'd0, errCnt}, 32'd0);
    chk("rst_state", {30'd0, dsState}, 32'd0);
    chk("rst_sel_decode", {28'd0, sel}, 32'h1);
    @(negedge clk);
    nReset = 1'b1;
    @(posedge clk);
    #1;

    // Decode table; data phases flow through the scoreboard
    for (int i = 0; i < 9; i++) begin
      cycle(vt[i].a, vt[i].t, vt[i].ns, 1'b1);
      chk($sformatf("sel_vec%0d", i), {28'd0, s_sel}, {28'd0, vt[i].s});
    end
    for (int i = 0; i < 3; i++) cycle(32'h0, IDLE, 1'b0, 1'b1);
    chk("tbl_errcnt_sat", {30'd0, s_err}, 32'd3);

    // Reset asserted in the middle of a peripheral wait state
    cycle(32'h1000_0000, NONSEQ, 1'b0, 1'b1);
    addr = 32'h3000_0000; trans = NONSEQ; prphReady = 4'h0;
    #2;
    chk("midwait_ready", {31'd0, ready}, 32'd0);
    nReset = 1'b0;
    #1;
    chk("midrst_ready", {31'd0, ready}, 32'd1);
    chk("midrst_resp", {31'd0, resp}, 32'd0);
    chk("midrst_rdata", rData, 32'd0);
    chk("midrst_errcnt", {30'd0, errCnt}, 32'd0);
    chk("midrst_sel", {28'd0, sel}, 32'h8);
    do_reset();

    // Wait states on peripheral 1 while addr moves to peripheral 3
    cycle(32'h1000_0000, NONSEQ, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cycle(32'h3000_0000, NONSEQ, 1'b0, 1'b0);
      chk($sformatf("wait%0d_ready", k), {31'd0, s_ready}, 32'd0);
      chk($sformatf("wait%0d_hold", k), s_rdata, 32'hCAFE_0001);
    end
    cycle(32'h3000_0000, NONSEQ, 1'b0, 1'b1);
    chk("wait_done_ready", {31'd0, s_ready}, 32'd1);

    // Unmapped NONSEQ: two-cycle ERROR, then IDLE to the same place is OKAY
    cycle(32'h5000_0000, NONSEQ, 1'b0, 1'b1);
    chk("p3_rdata", s_rdata, 32'hCAFE_0003);
    cycle(32'h5000_0000, IDLE, 1'b0, 1'b1);
    chk("unm_err1_ready", {31'd0, s_ready}, 32'd0);
    chk("unm_err1_resp", {31'd0, s_resp}, 32'd1);
    chk("unm_err1_cnt", {30'd0, s_err}, 32'd1);
    chk("unm_err1_state", {30'd0, s_st}, 32'd1);
    cycle(32'h5000_0000, IDLE, 1'b0, 1'b1);
    chk("unm_err2_ready", {31'd0, s_ready}, 32'd1);
    chk("unm_err2_resp", {31'd0, s_resp}, 32'd1);
    cycle(32'h5000_0000, IDLE, 1'b0, 1'b1);
    chk("unm_idle_ready", {31'd0, s_ready}, 32'd1);
    chk("unm_idle_resp", {31'd0, s_resp}, 32'd0);
    chk("unm_idle_cnt", {30'd0, s_err}, 32'd1);

    // Security violation, then the same transfer as secure
    cycle(32'h0000_0004, SEQ, 1'b1, 1'b1);
    chk("sec_sel_ns", {28'd0, s_sel}, 32'h0);
    cycle(32'h0000_0004, IDLE, 1'b0, 1'b1);
    chk("sec_err1_ready", {31'd0, s_ready}, 32'd0);
    chk("sec_err1_resp", {31'd0, s_resp}, 32'd1);
    cycle(32'h0000_0004, SEQ, 1'b0, 1'b1);
    chk("sec_sel_s", {28'd0, s_sel}, 32'h1);
    chk("sec_err2_resp", {31'd0, s_resp}, 32'd1);
    cycle(32'h0, IDLE, 1'b0, 1'b1);
    chk("sec_ok_rdata", s_rdata, 32'hCAFE_0000);
    chk("sec_cnt", {30'd0, s_err}, 32'd2);

    // Back-to-back unmapped errors with counter saturation
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cycle(32'h5000_0000, NONSEQ, 1'b0, 1'b1);
      if (k > 0) chk($sformatf("b2b%0d_err2_state", k), {30'd0, s_st}, 32'd2);
      cycle(32'h5000_0000, NONSEQ, 1'b0, 1'b1);
      chk($sformatf("b2b%0d_err1_ready", k), {31'd0, s_ready}, 32'd0);
      chk($sformatf("b2b%0d_err1_resp", k), {31'd0, s_resp}, 32'd1);
      chk($sformatf("b2b%0d_cnt", k), {30'd0, s_err}, {30'd0, exp_cnt[k]});
    end
    cycle(32'h2000_0000, NONSEQ, 1'b0, 1'b1);
    chk("b2b_last_err2_ready", {31'd0, s_ready}, 32'd1);
    cycle(32'h0, IDLE, 1'b0, 1'b1);
    chk("b2b_hit_rdata", s_rdata, 32'hCAFE_0002);
    chk("b2b_hit_state", {30'd0, s_st}, 32'd0);
    chk("b2b_hit_resp", {31'd0, s_resp}, 32'd0);

    for (int i = 0; i < 3; i++) cycle(32'h0, IDLE, 1'b0, 1'b1);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
